// File: rtl/note_scheduler_if.sv
// Pattern-request bus between the note scheduler and its falling-row slots.
//   req         : per-slot pattern request, held high until granted (slot -> scheduler)
//   grant       : one-hot, one-cycle grant (scheduler -> slot)
//   pattern_out : 4-bit lane pattern, valid in the grant cycle (scheduler -> slot)
// master = scheduler side, slave = slot side.
interface note_scheduler_if #(
  parameter int unsigned NUM_SLOTS = 4
) ();
  logic [NUM_SLOTS-1:0] req;
  logic [NUM_SLOTS-1:0] grant;
  logic [3:0]           pattern_out;

  modport master (input req, output grant, output pattern_out);
  modport slave  (output req, input grant, input pattern_out);
endinterface

// File: rtl/note_scheduler.sv
// Central sequencer for the four-lane falling-note game.
// Owns the game FSM, the shared step_tick divider, a round-robin pattern arbiter fed by a
// 16-bit Galois LFSR, the score accumulator and end-of-song drain.
//
// Ports:
//   CLOCK_25   : system clock
//   reset      : asynchronous active-low reset
//   start      : pulse, starts/restarts a song
//   pause      : pulse, toggles PLAYING/PAUSED
//   hit, miss  : per-slot score / miss pulses
//   slots      : request/grant/pattern bus (note_scheduler_if.master)
//   step_tick  : one-cycle row-advance pulse
//   slot_reset : one-cycle pulse after any start
//   score      : saturating score
//   combo      : current combo (0 unless COMBO_EN)
//   state      : 0 IDLE, 1 PLAYING, 2 PAUSED, 3 GAME_OVER
//   done       : high while GAME_OVER
//
// Optional feature: define COMBO_EN to enable the combo counter, the miss input and the
// doubled per-hit value once combo >= 10.
module note_scheduler #(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned TICK_DIV       = 200000,
  parameter int unsigned NOTES_PER_SONG = 64,
  parameter int unsigned DRAIN_TICKS    = 480,
  parameter int unsigned SCORE_W        = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 CLOCK_25,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic [NUM_SLOTS-1:0] hit,
  input  logic [NUM_SLOTS-1:0] miss,
  note_scheduler_if.master     slots,
  output logic                 step_tick,
  output logic                 slot_reset,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           combo,
  output logic [1:0]           state,
  output logic                 done
);

  localparam int unsigned DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NoteW  = $clog2(NOTES_PER_SONG + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_TICKS + 1);
  localparam int unsigned PtrW   = $clog2(NUM_SLOTS);
  localparam int unsigned CntW   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned SumW   = SCORE_W + 1;
  localparam logic [DivW-1:0]   DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [NoteW-1:0]  NoteMax  = NoteW'(NOTES_PER_SONG);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_TICKS);
  localparam logic [15:0]       LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StPaused   = 2'd2,
    StGameOver = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic                 tick_q, tick_d;
  logic [DrainW-1:0]    drain_q, drain_d;
  logic [NoteW-1:0]     note_q, note_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [3:0]           pat_q, pat_d;
  logic [NUM_SLOTS-1:0] req_q, grant_q, grant_d;
  logic [PtrW-1:0]      rr_q, rr_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic                 slot_reset_q;

  logic                 run, notes_done, drain_end, grant_en, gnt_any;
  logic [PtrW-1:0]      gnt_idx;
  logic [NUM_SLOTS-1:0] req_avail;
  logic [CntW-1:0]      hit_cnt;

  // A "run" cycle keeps playing: no start/pause is pending that would change the state.
  always_comb begin
    run        = (state_q == StPlaying) && !start && !pause;
    notes_done = (note_q == NoteMax);
  end

  // Tick divider and drain counter.
  always_comb begin
    div_d     = div_q;
    tick_d    = 1'b0;
    drain_d   = drain_q;
    drain_end = 1'b0;
    if (start || state_q == StIdle || state_q == StGameOver) begin
      div_d = '0;
    end else if (run) begin
      div_d  = (div_q == DivMax) ? '0 : div_q + 1'b1;
      tick_d = (div_d == DivMax);
    end
    if (start) begin
      drain_d = '0;
    end else if (tick_d && notes_done && drain_q != DrainMax) begin
      drain_d = drain_q + 1'b1;
    end
    drain_end = run && notes_done && (drain_d == DrainMax);
  end

  // Round-robin arbiter. The slot granted last cycle is masked because its registered
  // request still shows the level it held before it saw the grant.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    grant_en  = run && !drain_end;
    req_avail = req_q & ~grant_q;
    grant_d   = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    if (grant_en) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        idx = PtrW'((32'(rr_q) + k) % NUM_SLOTS);
        if (!gnt_any && req_avail[idx]) begin
          gnt_any      = 1'b1;
          gnt_idx      = idx;
          grant_d[idx] = 1'b1;
        end
      end
    end
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == PtrW'(NUM_SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pattern generation; grants past the song length carry an empty pattern.
  always_comb begin
    lfsr_d = lfsr_q;
    note_d = note_q;
    pat_d  = '0;
    if (start) begin
      lfsr_d = LFSR_SEED;
      note_d = '0;
    end else if (gnt_any && !notes_done) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
      note_d = note_q + 1'b1;
      pat_d  = (lfsr_q[3:0] != 4'd0) ? lfsr_q[3:0] : (4'b0001 << lfsr_q[5:4]);
    end
  end

  // Score and combo.
  always_comb begin
    logic [SumW-1:0] add;
    logic [SumW-1:0] sum;
    hit_cnt = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      hit_cnt = hit_cnt + CntW'(hit[i]);
    end
    score_d = score_q;
    combo_d = combo_q;
    add     = '0;
    sum     = '0;
    if (start) begin
      score_d = '0;
      combo_d = '0;
    end else if (state_q == StPlaying) begin
      add = SumW'(hit_cnt);
`ifdef COMBO_EN
      if (combo_q >= 8'd10) add = add << 1;
      if (|miss) begin
        combo_d = '0;
      end else begin
        combo_d = ({1'b0, combo_q} + 9'(hit_cnt) > 9'd255) ? 8'hFF : combo_q + 8'(hit_cnt);
      end
`endif
      sum     = {1'b0, score_q} + add;
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

`ifndef COMBO_EN
  logic unused_miss;
  assign unused_miss = ^miss;
`endif

  // FSM next state; start wins over pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = StPlaying;
      StPlaying: begin
        if (start)          state_d = StPlaying;
        else if (pause)     state_d = StPaused;
        else if (drain_end) state_d = StGameOver;
      end
      StPaused:   if (start || pause) state_d = StPlaying;
      StGameOver: if (start) state_d = StPlaying;
      default:    state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM outputs.
  always_comb begin
    state = state_q;
    done  = (state_q == StGameOver);
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      div_q        <= '0;
      tick_q       <= 1'b0;
      drain_q      <= '0;
      note_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      pat_q        <= '0;
      req_q        <= '0;
      grant_q      <= '0;
      rr_q         <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      slot_reset_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      tick_q       <= tick_d;
      drain_q      <= drain_d;
      note_q       <= note_d;
      lfsr_q       <= lfsr_d;
      pat_q        <= pat_d;
      req_q        <= slots.req;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      slot_reset_q <= start;
    end
  end

  always_comb begin
    slots.grant       = grant_q;
    slots.pattern_out = pat_q;
    step_tick         = tick_q;
    slot_reset        = slot_reset_q;
    score             = score_q;
    combo             = combo_q;
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: directed scenarios plus randomized arbitration and
// scoring, checked against a behavioural model kept here.
module tb_note_scheduler;
  localparam int unsigned NS  = 4;
  localparam int unsigned TD  = 4;
  localparam int unsigned NPS = 3;
  localparam int unsigned DT  = 2;
  localparam int unsigned SW  = 16;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef COMBO_EN
  localparam bit ComboOn = 1'b1;
`else
  localparam bit ComboOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [NS-1:0] hit = '0;
  logic [NS-1:0] miss = '0;
  logic          step_tick, slot_reset, done;
  logic [SW-1:0] score;
  logic [7:0]    combo;
  logic [1:0]    state;
  logic [NS-1:0] pend;

  int errors = 0;
  int checks = 0;
  int m_score = 0;
  int m_combo = 0;
  int m_ptr = 0;
  logic [3:0] exp_pat [4];

  note_scheduler_if #(.NUM_SLOTS(NS)) bus ();

  note_scheduler #(
    .NUM_SLOTS(NS), .TICK_DIV(TD), .NOTES_PER_SONG(NPS), .DRAIN_TICKS(DT),
    .SCORE_W(SW), .LFSR_SEED(SEED)
  ) dut (
    .CLOCK_25(clk), .reset(rst_n), .start(start), .pause(pause), .hit(hit), .miss(miss),
    .slots(bus), .step_tick(step_tick), .slot_reset(slot_reset), .score(score),
    .combo(combo), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] pat_of(input logic [15:0] v);
    if (v[3:0] != 4'd0) return v[3:0];
    return 4'b0001 << v[5:4];
  endfunction

  // Score/combo rules for one PLAYING cycle.
  task automatic model_apply(input logic [NS-1:0] h, input logic [NS-1:0] m);
    int n, v;
    n = $countones(h);
    v = 1;
    if (ComboOn) begin
      if (m_combo >= 10) v = 2;
      if (m != '0) m_combo = 0;
      else m_combo = (m_combo + n > 255) ? 255 : m_combo + n;
    end
    m_score = m_score + n * v;
    if (m_score > 65535) m_score = 65535;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_score = 0;
    m_combo = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (bus.grant !== '0) begin errors++; $display("FAIL rst_grant got %b want 0", bus.grant); end
    checks++; if (bus.pattern_out !== 4'd0) begin errors++; $display("FAIL rst_pattern got %b want 0", bus.pattern_out); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", step_tick); end
    checks++; if (slot_reset !== 1'b0) begin errors++; $display("FAIL rst_slot_reset got %b want 0", slot_reset); end
    checks++; if (score !== '0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL rst_combo got %0d want 0", combo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_start_tick();
    pulse_start();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d want 1", state); end
    checks++; if (slot_reset !== 1'b1) begin errors++; $display("FAIL slot_reset_pulse got %b want 1", slot_reset); end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (step_tick !== ((c % TD) == TD - 1)) begin
        errors++; $display("FAIL tick_period c=%0d got %b want %b", c, step_tick, (c % TD) == TD - 1);
      end
      if (c == 1) begin
        checks++; if (slot_reset !== 1'b0) begin errors++; $display("FAIL slot_reset_width got %b want 0", slot_reset); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_grants_drain();
    int n, g3, ticks, cyc_done, last;
    logic [NS-1:0] exp_g;
    n = 0; g3 = -1; ticks = 0; cyc_done = -1; last = -1;
    pulse_start();
    pend = 4'b1111; bus.req = pend;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.grant !== '0 && n < 4) begin
        exp_g = 4'b0001 << n;
        checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_order n=%0d got %b want %b", n, bus.grant, exp_g); end
        checks++; if (bus.pattern_out !== exp_pat[n]) begin errors++; $display("FAIL pattern n=%0d got %b want %b", n, bus.pattern_out, exp_pat[n]); end
        checks++; if (c !== (n == 0 ? 2 : last + 1)) begin errors++; $display("FAIL grant_timing n=%0d got cycle %0d", n, c); end
        pend = pend & ~bus.grant; bus.req = pend;
        last = c; n++;
        m_ptr = n % NS;
        if (n == NPS) g3 = c;
      end
      if (g3 >= 0 && c > g3) begin
        if (cyc_done >= 0) begin
          checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL over_tick got %b want 0", step_tick); end
        end else if (step_tick === 1'b1) ticks++;
        checks++; if (done !== (ticks >= DT)) begin errors++; $display("FAIL drain_done c=%0d got %b want %b", c, done, ticks >= DT); end
        checks++; if (state !== ((ticks >= DT) ? 2'd3 : 2'd1)) begin errors++; $display("FAIL drain_state c=%0d got %0d", c, state); end
        if (ticks >= DT && cyc_done < 0) cyc_done = c;
      end
      if (cyc_done >= 0 && c >= cyc_done + 4) break;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL grant_count got %0d want 4", n); end
    checks++; if (cyc_done < 0) begin errors++; $display("FAIL game_over_timeout got state %0d want 3", state); end
    pend = '0; bus.req = pend;
  endtask

  task automatic test_pause();
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL pre_pause_tick got %b want 1", step_tick); end
      end
    end
    pause = 1'b1; pend = 4'b0001; bus.req = pend;
    @(negedge clk);
    pause = 1'b0; hit = 4'b1111;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL paused_state got %0d want 2", state); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (step_tick !== 1'b0 || bus.grant !== '0) begin
        errors++; $display("FAIL paused_quiet i=%0d tick %b grant %b want 0", i, step_tick, bus.grant);
      end
      checks++; if (score !== '0) begin errors++; $display("FAIL paused_score got %0d want 0", score); end
    end
    hit = '0; pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    checks++; if (state !== 2'd1 || step_tick !== 1'b0) begin
      errors++; $display("FAIL resume state %0d tick %b want 1/0", state, step_tick);
    end
    @(negedge clk);
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL resume_tick got %b want 1", step_tick); end
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL resume_grant got %b want 0001", bus.grant); end
    checks++; if (bus.pattern_out !== exp_pat[0]) begin errors++; $display("FAIL resume_pattern got %b want %b", bus.pattern_out, exp_pat[0]); end
    pend = '0; bus.req = pend;
    m_ptr = 1;
  endtask

  task automatic test_random_arb();
    int n, nexp, last, es;
    for (int r = 0; r < 8; r++) begin
      pulse_start();
      pend = NS'($urandom_range(1, 15)); bus.req = pend;
      nexp = $countones(pend); n = 0; last = -1;
      for (int c = 1; c <= 8; c++) begin
        hit = NS'($urandom_range(0, 15));
        miss = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(1, 15)) : '0;
        @(negedge clk);
        model_apply(hit, miss);
        checks++; if (score !== SW'(m_score)) begin errors++; $display("FAIL rand_score got %0d want %0d", score, m_score); end
        checks++; if (combo !== 8'(m_combo)) begin errors++; $display("FAIL rand_combo got %0d want %0d", combo, m_combo); end
        if (bus.grant !== '0) begin
          es = -1;
          for (int k = 0; k < NS; k++) if (es < 0 && pend[(m_ptr + k) % NS]) es = (m_ptr + k) % NS;
          checks++; if (es < 0 || bus.grant !== (NS'(1) << es)) begin
            errors++; $display("FAIL rand_grant got %b want slot %0d", bus.grant, es);
          end
          checks++; if (bus.pattern_out !== ((n < NPS) ? exp_pat[n] : 4'd0)) begin
            errors++; $display("FAIL rand_pattern n=%0d got %b", n, bus.pattern_out);
          end
          checks++; if (c !== ((n == 0) ? 2 : last + 1)) begin errors++; $display("FAIL rand_timing got cycle %0d", c); end
          pend = pend & ~bus.grant; bus.req = pend;
          if (es >= 0) m_ptr = (es + 1) % NS;
          last = c; n++;
        end
      end
      hit = '0; miss = '0;
      checks++; if (n !== nexp) begin errors++; $display("FAIL rand_grant_count got %0d want %0d", n, nexp); end
      pend = '0; bus.req = pend;
    end
  endtask

  task automatic test_score_sat();
    int guard;
    pulse_start();
    guard = 0;
    while (m_score < 65400 && guard < 60000) begin
      hit = NS'($urandom_range(0, 15));
      miss = ($urandom_range(0, 63) == 0) ? 4'b0010 : '0;
      @(negedge clk);
      model_apply(hit, miss);
      guard++;
      if (guard % 1024 == 0) begin
        checks++; if (score !== SW'(m_score)) begin errors++; $display("FAIL ramp_score got %0d want %0d", score, m_score); end
        checks++; if (combo !== 8'(m_combo)) begin errors++; $display("FAIL ramp_combo got %0d want %0d", combo, m_combo); end
      end
    end
    hit = '0; miss = 4'b0001;
    @(negedge clk);
    model_apply(hit, miss);
    hit = 4'b0001; miss = 4'b0001;
    guard = 0;
    while (m_score < 65534 && guard < 400) begin
      @(negedge clk);
      model_apply(hit, miss);
      guard++;
    end
    hit = '0; miss = '0;
    checks++; if (score !== 16'd65534) begin errors++; $display("FAIL near_max got %0d want 65534", score); end
    hit = 4'b0101;
    @(negedge clk);
    hit = 4'b1111;
    checks++; if (score !== 16'd65535) begin errors++; $display("FAIL saturate got %0d want 65535", score); end
    @(negedge clk);
    hit = '0;
    checks++; if (score !== 16'd65535) begin errors++; $display("FAIL saturate_hold got %0d want 65535", score); end
  endtask

  task automatic test_combo();
    pulse_start();
    hit = 4'b0001;
    repeat (10) @(negedge clk);
    hit = '0;
    checks++; if (score !== 16'd10) begin errors++; $display("FAIL combo_score10 got %0d want 10", score); end
    checks++; if (combo !== (ComboOn ? 8'd10 : 8'd0)) begin errors++; $display("FAIL combo10 got %0d", combo); end
    hit = 4'b0001;
    @(negedge clk);
    hit = '0;
    checks++; if (score !== (ComboOn ? 16'd12 : 16'd11)) begin errors++; $display("FAIL combo_bonus got %0d", score); end
    hit = 4'b0001; miss = 4'b0001;
    @(negedge clk);
    hit = '0; miss = '0;
    checks++; if (score !== (ComboOn ? 16'd14 : 16'd12)) begin errors++; $display("FAIL miss_score got %0d", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL miss_clear got %0d want 0", combo); end
  endtask

  initial begin
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < 4; i++) begin
      exp_pat[i] = (i < NPS) ? pat_of(v) : 4'd0;
      v = lfsr_next(v);
    end
    pend = '0;
    bus.req = '0;
    test_reset();
    test_start_tick();
    test_grants_drain();
    test_pause();
    test_random_arb();
    test_score_sat();
    test_combo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at state %0d", state);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Central sequencer for the four-lane falling-note game.
- Owns the game FSM and the shared vertical-step tick.
- Supplies new 4-bit lane patterns to NUM_SLOTS falling-row slots through a round-robin arbiter.
- Accumulates score from the slots' hit pulses and signals end of song.

Parameters:
- NUM_SLOTS, 4, number of falling-row slots requesting patterns (2..8)
- TICK_DIV, 200000, CLOCK_25 cycles per step_tick
- NOTES_PER_SONG, 64, non-empty patterns issued per song
- DRAIN_TICKS, 480, step ticks after last note before GAME_OVER
- SCORE_W, 16, score width
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset and on start

Ports:
- CLOCK_25  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-low; 0 = reset
- start  in  1  one-cycle pulse; starts/restarts a song
- pause  in  1  one-cycle pulse; toggles PLAYING/PAUSED
- req  in  NUM_SLOTS  per-slot pattern request (level, held until granted)
- hit  in  NUM_SLOTS  per-slot score pulse
- miss  in  NUM_SLOTS  per-slot miss pulse (used only with COMBO_EN)
- grant  out  NUM_SLOTS  one-hot, one-cycle grant
- pattern_out  out  4  lane pattern, valid in grant cycle
- step_tick  out  1  one-cycle row-advance pulse
- slot_reset  out  1  one-cycle pulse; slots reload initial y
- score  out  SCORE_W  accumulated score
- combo  out  8  current combo (0 without COMBO_EN)
- state  out  2  0 IDLE, 1 PLAYING, 2 PAUSED, 3 GAME_OVER
- done  out  1  high while GAME_OVER

Behaviour:
- Reset (reset=0, async): state IDLE; grant, pattern_out, step_tick and slot_reset 0; score 0; combo 0; LFSR = LFSR_SEED; RR pointer = slot 0; note and drain counters 0.
- FSM transitions:
  - IDLE --start--> PLAYING
  - PLAYING --pause--> PAUSED; PAUSED --pause--> PLAYING
  - PLAYING --drain done--> GAME_OVER
  - GAME_OVER --start--> PLAYING
- start has priority over pause in the same cycle. start in PLAYING or PAUSED restarts the song.
- On any start: slot_reset pulses in the next cycle. Score, combo, note counter, drain counter, tick divider and LFSR are reinitialised. RR pointer is kept.
- Tick divider:
  - Counts only in PLAYING; frozen (value held) in PAUSED; cleared in IDLE and GAME_OVER.
  - step_tick pulses in the cycle the count reaches TICK_DIV-1, then the count wraps to 0.
- Arbiter:
  - Active only in PLAYING.
  - Requests are registered; grant appears 1 cycle after req is sampled high.
  - Search starts at the slot after the last granted slot and wraps modulo NUM_SLOTS. At most one grant per cycle.
  - A slot granted in cycle N is masked in cycle N+1 so that it can drop req.
  - Requests held through PAUSED are served after resume.
- Pattern generation:
  - Galois LFSR, 16 bits, taps mask 16'hB400; advances once per grant.
  - pattern_out = lfsr[3:0], or 4'b0001 << lfsr[5:4] when lfsr[3:0] == 0.
  - Once NOTES_PER_SONG patterns have been issued, further grants output 4'b0000 and the LFSR does not advance.
- Drain:
  - After the last note is issued, the drain counter counts step_ticks.
  - GAME_OVER is entered on the cycle the count reaches DRAIN_TICKS.
- Score:
  - Updated in PLAYING only. Each cycle, add popcount(hit) times the per-hit value (1 without COMBO_EN), so simultaneous hits all count.
  - Saturates at 2^SCORE_W-1.
  - hit is ignored in other states.
- Outputs are registered.

Optional Feature:
- Macro: COMBO_EN.
- With COMBO_EN defined:
  - combo increments by popcount(hit) per cycle and saturates at 255.
  - Any miss bit set clears combo to 0; the clear wins over a simultaneous hit.
  - Per-hit value is 2 when combo >= 10 before the update, otherwise 1.
- Without COMBO_EN: combo is tied to 0, miss is ignored, per-hit value is 1.

Test Plan:
- Reset, start pulse, TICK_DIV=4 -> slot_reset pulses 1 cycle after start; step_tick pulses every 4th cycle; state=1.
- req=4'b1111 held, dropped on grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles; the first pattern_out is derived from seed 16'hACE1.
- pause during PLAYING with divider at 2, hold 10 cycles, pause again -> no step_tick and no grants while paused; the next tick comes 2 cycles after resume.
- NOTES_PER_SONG=3, DRAIN_TICKS=2 -> 4th grant outputs 4'b0000; GAME_OVER and done=1 on the 2nd step_tick after the 3rd note.
- hit=4'b0101 in one cycle with score=65534, SCORE_W=16 -> score saturates at 65535.
- COMBO_EN: 10 single hits -> score 10, combo 10; next hit -> score 12; miss together with hit -> combo 0, score 14.
